grant_dispatcher: RTL and testbench
===================================

Name: grant_dispatcher

Overview:
- Downstream consumer of the round-robin arbiter's one-hot grant in the multi-port cache.
- Collects per-input-port transfer requests with beat counts and presents them to the arbiter as its request vector.
- Latches the winning grant and sequences a multi-beat read transfer for that port over a valid/ready interface.
- Returns a one-cycle acknowledge to the served port; arbitration is held off while a transfer is in flight.

Parameters:
- N_REQ, 16, number of input ports; must match the arbiter's N_REQ; minimum 2.
- LEN_W, 8, width of the per-port length field; field value = beats-1, so 1..2^LEN_W beats.
- PORT_W, $clog2(N_REQ), width of the encoded port index.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_port_req  in  N_REQ  per-port transfer request level; held until o_port_ack.
- i_port_len  in  N_REQ*LEN_W  per-port beats-1; port k occupies bits [k*LEN_W +: LEN_W]; stable while the request is high.
- o_port_ack  out  N_REQ  one-hot, one-cycle completion pulse to the served port.
- o_arb_req  out  N_REQ  request vector to the arbiter.
- i_arb_grant  in  N_REQ  registered grant from the arbiter; nominally a one-hot single-cycle pulse.
- o_rd_vld  out  1  read beat valid.
- o_rd_port  out  PORT_W  port index of the current transfer.
- o_rd_beat  out  LEN_W  beat number within the transfer, starting at 0.
- i_rd_rdy  in  1  downstream ready.
- o_busy  out  1  high in XFER and DONE.
- o_err_grant  out  1  one-cycle pulse on an illegal grant.

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; all outputs 0; latched index, length, beat counter and ack mask cleared.
- FSM states:
  - IDLE: o_arb_req = i_port_req & ~ack_mask. ack_mask is the one-hot of the port acked in the preceding DONE cycle, valid for the first IDLE cycle only, then 0.
    - Valid grant: i_arb_grant is one-hot and its bit is set in the o_arb_req of the same cycle. Action: latch idx = encode(grant) and len = i_port_len[idx]; clear the beat counter; go to XFER next cycle.
    - Illegal grant: any nonzero grant that is not one-hot or targets a non-requesting port. Action: pulse o_err_grant next cycle; stay in IDLE; latch nothing.
  - XFER: o_arb_req=0; o_rd_vld=1; o_rd_port=idx; o_rd_beat=counter.
    - On vld&rdy with counter==len: go to DONE.
    - On vld&rdy otherwise: counter+1.
    - rdy low: hold all outputs stable.
  - DONE: o_rd_vld=0; o_port_ack[idx]=1 for exactly this cycle; o_arb_req=0; set ack_mask=onehot(idx); go to IDLE.
- Any i_arb_grant seen outside IDLE is ignored: no latch, no error.
- Outputs o_rd_*, o_port_ack, o_err_grant and o_busy are registered (driven from state/flops). o_arb_req is combinational from i_port_req and state.
- Latency:
  - Grant seen in cycle t → first o_rd_vld in t+1.
  - Final handshake in cycle u → ack in u+1 → IDLE (re-arbitration request) in u+2.
  - Minimum transfer occupancy = len+3 cycles, including the grant cycle.
- Length: len=0 means 1 beat; len=2^LEN_W-1 means 2^LEN_W beats. The counter does not wrap within a transfer.
- i_port_req dropping mid-XFER for the served port: ignored; the transfer completes and the ack is still issued.
- i_port_len changing mid-XFER: ignored; the length was latched at grant.
- Reset asserted mid-XFER: immediate return to IDLE; o_rd_vld drops asynchronously; no ack is issued.

Test Plan:
- Port 3 requests with len=2, arbiter grants bit 3 → o_rd_vld for 3 beats with o_rd_port=3 and o_rd_beat 0,1,2 (rdy held 1); o_port_ack=16'h0008 one cycle later; o_busy high for 4 cycles.
- Ports 1 and 5 request with len=0 and real arbiter instantiated → grants serviced 1 then 5; each gets a single beat and an ack; no o_err_grant.
- Port 0 with len=3, i_rd_rdy pattern 1,0,0,1,1,0,1 → beat values hold during rdy low; exactly 4 handshakes; ack after the 4th.
- In IDLE drive i_arb_grant=16'h0006, then 16'h0010 with port 4 not requesting → o_err_grant pulses twice; state stays IDLE; no o_rd_vld.
- Port 2 keeps its req high for one cycle after the ack → o_arb_req[2]=0 in the first IDLE cycle, then reasserted.
- Port 7 with len=255, assert i_rst_n=0 at beat 100 → o_rd_vld=0 immediately; no ack; after release, a new request is accepted normally.

Source files
------------

// File: rtl/grant_dispatcher_if.sv
// Read-beat channel from the grant dispatcher to the downstream cache datapath.
// The master drives valid/port/beat and the slave returns ready.
interface grant_dispatcher_if #(
    parameter int PORT_W = 4,
    parameter int LEN_W  = 8
);
    logic              rd_vld;
    logic [PORT_W-1:0] rd_port;
    logic [LEN_W-1:0]  rd_beat;
    logic              rd_rdy;

    modport master (
        output rd_vld,
        output rd_port,
        output rd_beat,
        input  rd_rdy
    );

    modport slave (
        input  rd_vld,
        input  rd_port,
        input  rd_beat,
        output rd_rdy
    );
endinterface

// File: rtl/grant_dispatcher.sv
// Latches a one-hot arbiter grant and streams len+1 read beats for that port; first beat one cycle after the grant.
// Beats hold while rd_rdy is low; the port ack follows the last handshake, and arbitration stays masked until then.
module grant_dispatcher #(
    parameter int N_REQ  = 16,
    parameter int LEN_W  = 8,
    parameter int PORT_W = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_port_req,
    input  logic [N_REQ*LEN_W-1:0] i_port_len,
    output logic [N_REQ-1:0]       o_port_ack,
    output logic [N_REQ-1:0]       o_arb_req,
    input  logic [N_REQ-1:0]       i_arb_grant,
    grant_dispatcher_if.master     rd,
    output logic                   o_busy,
    output logic                   o_err_grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [PORT_W-1:0]   idx_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [N_REQ-1:0]    ack_mask_q;
    logic [N_REQ-1:0]    port_ack_q;
    logic                rd_vld_q;
    logic                busy_q;
    logic                err_q;

    logic [PORT_W-1:0]   gnt_idx;
    logic [LEN_W-1:0]    gnt_len;
    logic                gnt_any;
    logic                gnt_valid;
    logic [N_REQ-1:0]    idx_onehot;

    // The just-served port is masked for one IDLE cycle so a lingering request cannot win again immediately.
    always_comb begin
        o_arb_req = '0;
        if (state_q == S_IDLE) begin
            o_arb_req = i_port_req & ~ack_mask_q;
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (i_arb_grant[k]) begin
                gnt_idx = PORT_W'(k);
            end
        end
    end

    assign gnt_any    = |i_arb_grant;
    assign gnt_valid  = $onehot(i_arb_grant) && (|(i_arb_grant & o_arb_req));
    assign gnt_len    = i_port_len[int'(gnt_idx)*LEN_W +: LEN_W];
    assign idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            ack_mask_q <= '0;
            port_ack_q <= '0;
            rd_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            port_ack_q <= '0;
            ack_mask_q <= '0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid) begin
                        idx_q    <= gnt_idx;
                        len_q    <= gnt_len;
                        cnt_q    <= '0;
                        rd_vld_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_XFER;
                    end else if (gnt_any) begin
                        err_q <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (rd.rd_rdy) begin
                        if (cnt_q == len_q) begin
                            rd_vld_q   <= 1'b0;
                            port_ack_q <= idx_onehot;
                            state_q    <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    ack_mask_q <= idx_onehot;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    rd_vld_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign rd.rd_vld  = rd_vld_q;
    assign rd.rd_port = idx_q;
    assign rd.rd_beat = cnt_q;
    assign o_port_ack = port_ack_q;
    assign o_busy     = busy_q;
    assign o_err_grant = err_q;

endmodule

// File: tb/tb_grant_dispatcher.sv
// Randomized and directed bench for grant_dispatcher against a transaction-level model.
module tb_grant_dispatcher;

    logic         clk;
    logic         rst_n;
    logic [15:0]  port_req;
    logic [127:0] port_len;
    logic [15:0]  port_ack;
    logic [15:0]  arb_req;
    logic [15:0]  arb_grant;
    logic         busy;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    grant_dispatcher_if #(.PORT_W(4), .LEN_W(8)) rd ();

    grant_dispatcher #(.N_REQ(16), .LEN_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_port_req  (port_req),
        .i_port_len  (port_len),
        .o_port_ack  (port_ack),
        .o_arb_req   (arb_req),
        .i_arb_grant (arb_grant),
        .rd          (rd),
        .o_busy      (busy),
        .o_err_grant (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_len(input int p, input int l);
        port_len[p*8 +: 8] = 8'(l);
    endtask

    function automatic logic [15:0] oh(input int p);
        logic [15:0] one;
        one = 16'h0001;
        return one << p;
    endfunction

    function automatic int rr_pick(input logic [15:0] v, input int last);
        for (int k = 1; k <= 16; k++) begin
            if (v[(last + k) % 16]) return (last + k) % 16;
        end
        return -1;
    endfunction

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (rd.rd_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", rd.rd_vld); end
        n_cmp++; if (port_ack !== 16'h0) begin n_bad++; $display("FAIL reset_ack: got %h want 0000", port_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (rd.rd_beat !== 8'd0) begin n_bad++; $display("FAIL reset_beat: got %0d want 0", rd.rd_beat); end
        n_cmp++; if (rd.rd_port !== 4'd0) begin n_bad++; $display("FAIL reset_port: got %0d want 0", rd.rd_port); end
        port_req = 16'h0041;
        #1;
        n_cmp++; if (arb_req !== 16'h0041) begin n_bad++; $display("FAIL reset_arb_req: got %h want 0041", arb_req); end
        port_req = 16'h0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_port3();
        int busy_cnt;
        busy_cnt = 0;
        port_len = '0;
        set_len(3, 2);
        rd.rd_rdy = 1'b1;
        port_req = 16'h0008;
        #1;
        n_cmp++; if (arb_req !== 16'h0008) begin n_bad++; $display("FAIL p3_arb_req: got %h want 0008", arb_req); end
        arb_grant = 16'h0008;
        step();
        arb_grant = 16'h0;
        for (int b = 0; b < 3; b++) begin
            if (busy) busy_cnt++;
            n_cmp++;
            if (rd.rd_vld !== 1'b1 || rd.rd_port !== 4'd3 || rd.rd_beat !== 8'(b) || port_ack !== 16'h0) begin
                n_bad++;
                $display("FAIL p3_beat%0d: got vld=%b port=%0d beat=%0d ack=%h want vld=1 port=3 beat=%0d ack=0000",
                         b, rd.rd_vld, rd.rd_port, rd.rd_beat, port_ack, b);
            end
            step();
        end
        if (busy) busy_cnt++;
        n_cmp++; if (port_ack !== 16'h0008 || rd.rd_vld !== 1'b0) begin n_bad++; $display("FAIL p3_ack: got ack=%h vld=%b want ack=0008 vld=0", port_ack, rd.rd_vld); end
        port_req = 16'h0;
        step();
        if (busy) busy_cnt++;
        n_cmp++; if (port_ack !== 16'h0) begin n_bad++; $display("FAIL p3_ack_pulse: got %h want 0000", port_ack); end
        n_cmp++; if (busy_cnt !== 4) begin n_bad++; $display("FAIL p3_busy_cycles: got %0d want 4", busy_cnt); end
    endtask

    task automatic test_rr_two_ports();
        logic [15:0] nxt;
        logic [15:0] acks[$];
        int hs_p[$];
        int hs_b[$];
        int last, errs, p;
        nxt = '0; last = 0; errs = 0;
        port_len = '0;
        rd.rd_rdy = 1'b1;
        port_req = 16'h0022;
        for (int c = 0; c < 40; c++) begin
            arb_grant = nxt;
            #1;
            if (rd.rd_vld && rd.rd_rdy) begin
                hs_p.push_back(int'(rd.rd_port));
                hs_b.push_back(int'(rd.rd_beat));
            end
            if (port_ack != 16'h0) begin
                acks.push_back(port_ack);
                port_req = port_req & ~port_ack;
            end
            if (err) errs++;
            nxt = '0;
            if (arb_req != 16'h0) begin
                p = rr_pick(arb_req, last);
                nxt = oh(p);
                last = p;
            end
            step();
        end
        arb_grant = '0;
        n_cmp++; if (hs_p.size() !== 2) begin n_bad++; $display("FAIL rr_beats: got %0d handshakes want 2", hs_p.size()); end
        if (hs_p.size() >= 2) begin
            n_cmp++; if (hs_p[0] !== 1 || hs_b[0] !== 0) begin n_bad++; $display("FAIL rr_first: got port=%0d beat=%0d want port=1 beat=0", hs_p[0], hs_b[0]); end
            n_cmp++; if (hs_p[1] !== 5 || hs_b[1] !== 0) begin n_bad++; $display("FAIL rr_second: got port=%0d beat=%0d want port=5 beat=0", hs_p[1], hs_b[1]); end
        end
        n_cmp++; if (acks.size() !== 2) begin n_bad++; $display("FAIL rr_acks: got %0d acks want 2", acks.size()); end
        if (acks.size() >= 2) begin
            n_cmp++; if (acks[0] !== 16'h0002 || acks[1] !== 16'h0020) begin n_bad++; $display("FAIL rr_ack_order: got %h,%h want 0002,0020", acks[0], acks[1]); end
        end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL rr_err: got %0d err pulses want 0", errs); end
    endtask

    task automatic test_backpressure();
        bit pat[7];
        int nh, early;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        nh = 0; early = 0;
        port_len = '0;
        set_len(0, 3);
        port_req = 16'h0001;
        rd.rd_rdy = 1'b1;
        arb_grant = 16'h0001;
        step();
        arb_grant = '0;
        for (int i = 0; i < 7; i++) begin
            rd.rd_rdy = pat[i];
            if (port_ack != 16'h0) early++;
            n_cmp++;
            if (rd.rd_vld !== 1'b1 || rd.rd_beat !== 8'(nh) || rd.rd_port !== 4'd0) begin
                n_bad++;
                $display("FAIL bp_cycle%0d: got vld=%b beat=%0d port=%0d want vld=1 beat=%0d port=0",
                         i, rd.rd_vld, rd.rd_beat, rd.rd_port, nh);
            end
            if (pat[i]) nh++;
            step();
        end
        rd.rd_rdy = 1'b1;
        n_cmp++; if (port_ack !== 16'h0001 || rd.rd_vld !== 1'b0) begin n_bad++; $display("FAIL bp_ack: got ack=%h vld=%b want ack=0001 vld=0", port_ack, rd.rd_vld); end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL bp_early_ack: got %0d early acks want 0", early); end
        port_req = '0;
        step();
        n_cmp++; if (busy !== 1'b0 || rd.rd_vld !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got busy=%b vld=%b want 0 0", busy, rd.rd_vld); end
    endtask

    task automatic test_illegal_grant();
        port_len = '0;
        port_req = 16'h0006;
        arb_grant = 16'h0006;
        step();
        arb_grant = '0;
        n_cmp++; if (err !== 1'b1 || rd.rd_vld !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ill_multi: got err=%b vld=%b busy=%b want 1 0 0", err, rd.rd_vld, busy); end
        step();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ill_pulse1: got err=%b want 0", err); end
        arb_grant = 16'h0010;
        step();
        arb_grant = '0;
        n_cmp++; if (err !== 1'b1 || rd.rd_vld !== 1'b0) begin n_bad++; $display("FAIL ill_noreq: got err=%b vld=%b want 1 0", err, rd.rd_vld); end
        step();
        #1;
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0 || rd.rd_vld !== 1'b0) begin n_bad++; $display("FAIL ill_after: got err=%b busy=%b vld=%b want 0 0 0", err, busy, rd.rd_vld); end
        n_cmp++; if (arb_req !== 16'h0006) begin n_bad++; $display("FAIL ill_still_idle: got arb_req=%h want 0006", arb_req); end
        port_req = '0;
        step();
    endtask

    task automatic test_ack_mask();
        int c;
        port_len = '0;
        set_len(2, 0);
        port_req = 16'h0004;
        rd.rd_rdy = 1'b1;
        arb_grant = 16'h0004;
        step();
        arb_grant = '0;
        for (c = 0; c < 10; c++) begin
            if (port_ack != 16'h0) break;
            step();
        end
        n_cmp++; if (port_ack !== 16'h0004) begin n_bad++; $display("FAIL mask_ack: got %h want 0004", port_ack); end
        step();
        #1;
        n_cmp++; if (arb_req !== 16'h0000) begin n_bad++; $display("FAIL mask_first_idle: got %h want 0000", arb_req); end
        step();
        #1;
        n_cmp++; if (arb_req !== 16'h0004) begin n_bad++; $display("FAIL mask_reassert: got %h want 0004", arb_req); end
        port_req = '0;
        step();
    endtask

    task automatic test_reset_mid_xfer();
        int acks;
        acks = 0;
        port_len = '0;
        set_len(7, 255);
        port_req = 16'h0080;
        rd.rd_rdy = 1'b1;
        arb_grant = 16'h0080;
        step();
        arb_grant = '0;
        for (int b = 0; b < 100; b++) step();
        n_cmp++; if (rd.rd_vld !== 1'b1 || rd.rd_beat !== 8'd100) begin n_bad++; $display("FAIL rst_mid_beat: got vld=%b beat=%0d want 1 100", rd.rd_vld, rd.rd_beat); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rd.rd_vld !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_async: got vld=%b busy=%b want 0 0", rd.rd_vld, busy); end
        step();
        if (port_ack != 16'h0) acks++;
        step();
        if (port_ack != 16'h0) acks++;
        rst_n = 1'b1;
        step();
        if (port_ack != 16'h0) acks++;
        #1;
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rst_mid_noack: got %0d acks want 0", acks); end
        n_cmp++; if (arb_req !== 16'h0080) begin n_bad++; $display("FAIL rst_mid_rearb: got %h want 0080", arb_req); end
        arb_grant = 16'h0080;
        step();
        arb_grant = '0;
        for (int b = 0; b < 256; b++) begin
            n_cmp++;
            if (rd.rd_vld !== 1'b1 || rd.rd_port !== 4'd7 || rd.rd_beat !== 8'(b)) begin
                n_bad++;
                $display("FAIL long_beat%0d: got vld=%b port=%0d beat=%0d want 1 7 %0d", b, rd.rd_vld, rd.rd_port, rd.rd_beat, b);
            end
            step();
        end
        n_cmp++; if (port_ack !== 16'h0080 || rd.rd_vld !== 1'b0) begin n_bad++; $display("FAIL long_ack: got ack=%h vld=%b want 0080 0", port_ack, rd.rd_vld); end
        port_req = '0;
        step();
    endtask

    task automatic test_random();
        int q_p[$];
        int q_b[$];
        int lens[16];
        logic [15:0] pend, mask, mask_nxt, nxt_g, exp_arb, exp_ack;
        int last, g_port, ack_port, done, issued, cyc, p, b;
        bit ack_due, ack_due_nxt, active, exp_vld;
        pend = '0; mask = '0; nxt_g = '0; last = 15; g_port = 0;
        ack_port = 0; done = 0; issued = 0; ack_due = 1'b0;
        port_len = '0; port_req = '0; arb_grant = '0;
        for (cyc = 0; cyc < 20000; cyc++) begin
            if (issued < 40) begin
                for (int k = 0; k < 16; k++) begin
                    if (!pend[k] && $urandom_range(0, 7) == 0) begin
                        lens[k] = int'($urandom_range(0, 7));
                        set_len(k, lens[k]);
                        pend[k] = 1'b1;
                        issued++;
                    end
                end
            end
            port_req  = pend;
            rd.rd_rdy = ($urandom_range(0, 9) < 7);
            arb_grant = nxt_g;
            #1;
            exp_vld = (q_p.size() != 0);
            active  = exp_vld || ack_due;
            exp_arb = active ? 16'h0 : (pend & ~mask);
            exp_ack = ack_due ? oh(ack_port) : 16'h0;
            n_cmp++; if (arb_req !== exp_arb) begin n_bad++; $display("FAIL rnd_arb_req c%0d: got %h want %h", cyc, arb_req, exp_arb); end
            n_cmp++; if (rd.rd_vld !== exp_vld) begin n_bad++; $display("FAIL rnd_vld c%0d: got %b want %b", cyc, rd.rd_vld, exp_vld); end
            n_cmp++; if (busy !== active) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, active); end
            n_cmp++; if (port_ack !== exp_ack) begin n_bad++; $display("FAIL rnd_ack c%0d: got %h want %h", cyc, port_ack, exp_ack); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want 0", cyc, err); end
            ack_due_nxt = 1'b0;
            if (exp_vld && rd.rd_rdy) begin
                p = q_p.pop_front();
                b = q_b.pop_front();
                n_cmp++;
                if (rd.rd_port !== 4'(p) || rd.rd_beat !== 8'(b)) begin
                    n_bad++;
                    $display("FAIL rnd_beat c%0d: got port=%0d beat=%0d want port=%0d beat=%0d", cyc, rd.rd_port, rd.rd_beat, p, b);
                end
                if (q_p.size() == 0) begin
                    ack_due_nxt = 1'b1;
                    ack_port = p;
                end
            end
            mask_nxt = '0;
            if (ack_due) begin
                mask_nxt = oh(ack_port);
                pend[ack_port] = 1'b0;
                done++;
            end
            if (nxt_g != 16'h0) begin
                for (int j = 0; j <= lens[g_port]; j++) begin
                    q_p.push_back(g_port);
                    q_b.push_back(j);
                end
            end
            nxt_g = '0;
            if (exp_arb != 16'h0 && arb_grant == 16'h0) begin
                g_port = rr_pick(exp_arb, last);
                last = g_port;
                nxt_g = oh(g_port);
            end
            ack_due = ack_due_nxt;
            mask = mask_nxt;
            if (issued >= 40 && pend == 16'h0 && q_p.size() == 0 && !ack_due && nxt_g == 16'h0) break;
            step();
        end
        arb_grant = '0;
        port_req = '0;
        rd.rd_rdy = 1'b1;
        n_cmp++; if (cyc >= 20000) begin n_bad++; $display("FAIL rnd_timeout: got %0d cycles want < 20000", cyc); end
        n_cmp++; if (done !== issued) begin n_bad++; $display("FAIL rnd_done: got %0d completed want %0d", done, issued); end
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        port_req = '0;
        port_len = '0;
        arb_grant = '0;
        rd.rd_rdy = 1'b0;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_single_port3();
        test_rr_two_ports();
        test_backpressure();
        test_illegal_grant();
        test_ack_mask();
        test_reset_mid_xfer();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
